// File: rtl/led_seq_pkg.sv
// Shared mode encoding, bounce direction and per-mode initial patterns
// for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FLASH  = 2'd3
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Initial patterns are given as low bits, zero-extended to the LED width.
    localparam logic [1:0] INIT_BINARY = 2'b00;
    localparam logic [1:0] INIT_WALK   = 2'b01;
    localparam logic [1:0] INIT_BOUNCE = 2'b01;
    localparam logic [1:0] INIT_FLASH  = 2'b00;

    function automatic logic [1:0] init_pattern_bits(input mode_e m);
        logic [1:0] bits_s;
        case (m)
            MODE_BINARY: bits_s = INIT_BINARY;
            MODE_WALK:   bits_s = INIT_WALK;
            MODE_BOUNCE: bits_s = INIT_BOUNCE;
            MODE_FLASH:  bits_s = INIT_FLASH;
            default:     bits_s = 2'b00;
        endcase
        return bits_s;
    endfunction

endpackage

// File: rtl/led_sequencer_step_sync.sv
// Three-flop synchronizer with rising-edge detect; flops reset high so an
// input that is already high when reset releases never produces a pulse.
module step_sync (
    input  logic clk,
    input  logic rstn,
    input  logic in,
    output logic pulse
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain plus one extra stage for edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
            s3_r <= 1'b1;
        end else begin
            s1_r <= in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign pulse = s2_r & ~s3_r;

endmodule

// File: rtl/led_sequencer.sv
// Animated LED pattern generator: four patterns advanced by a synchronized
// step wave, with global PWM dimming on a registered LED output.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_WIDTH = 8,
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 step_in,
    input  logic [1:0]           mode,
    input  logic [PWM_WIDTH-1:0] brightness,
    output logic [LED_WIDTH-1:0] led
);

    localparam logic [LED_WIDTH-1:0] PAT_ZERO = {LED_WIDTH{1'b0}};
    localparam logic [LED_WIDTH-1:0] PAT_ONE  = LED_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0] PAT_TWO  = LED_WIDTH'(2);
    localparam logic [LED_WIDTH-1:0] MSB_ONLY = PAT_ONE << (LED_WIDTH - 1);

    mode_e                  mode_sel_s;
    mode_e                  mode_r;
    logic                   mode_change_s;
    logic                   step_s;
    logic [LED_WIDTH-1:0]   pattern_r;
    logic [LED_WIDTH-1:0]   pattern_nxt_s;
    logic                   dir_r;
    logic                   dir_nxt_s;
    logic [PWM_WIDTH-1:0]   pwm_cnt_r;
    logic                   pwm_on_s;
    logic [LED_WIDTH-1:0]   led_r;

    step_sync u_step_sync (
        .clk   (clk),
        .rstn  (rstn),
        .in    (step_in),
        .pulse (step_s)
    );

    assign mode_sel_s    = mode_e'(mode);
    assign mode_change_s = (mode_sel_s != mode_r);
    // Full-scale brightness must stay lit on the one count where cnt < max fails.
    assign pwm_on_s      = (pwm_cnt_r < brightness) | (&brightness);

    // Pattern/direction next state: mode change outranks a same-cycle step
    always_comb begin
        pattern_nxt_s = pattern_r;
        dir_nxt_s     = dir_r;
        if (mode_change_s) begin
            pattern_nxt_s = LED_WIDTH'(init_pattern_bits(mode_sel_s));
            dir_nxt_s     = DIR_LEFT;
        end else if (step_s) begin
            case (mode_r)
                MODE_BINARY: begin
                    pattern_nxt_s = pattern_r + PAT_ONE;
                end
                MODE_WALK: begin
                    pattern_nxt_s = {pattern_r[LED_WIDTH-2:0], pattern_r[LED_WIDTH-1]};
                end
                MODE_BOUNCE: begin
                    if (dir_r == DIR_LEFT) begin
                        if (pattern_r == MSB_ONLY) begin
                            pattern_nxt_s = pattern_r >> 1;
                            dir_nxt_s     = DIR_RIGHT;
                        end else begin
                            pattern_nxt_s = pattern_r << 1;
                        end
                    end else begin
                        if (pattern_r == PAT_ONE) begin
                            pattern_nxt_s = PAT_TWO;
                            dir_nxt_s     = DIR_LEFT;
                        end else begin
                            pattern_nxt_s = pattern_r >> 1;
                        end
                    end
                end
                MODE_FLASH: begin
                    pattern_nxt_s = ~pattern_r;
                end
                default: begin
                    pattern_nxt_s = pattern_r;
                end
            endcase
        end else begin
            pattern_nxt_s = pattern_r;
            dir_nxt_s     = dir_r;
        end
    end

    // Mode, pattern, PWM counter and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_r    <= MODE_BINARY;
            pattern_r <= PAT_ZERO;
            dir_r     <= DIR_LEFT;
            pwm_cnt_r <= {PWM_WIDTH{1'b0}};
            led_r     <= PAT_ZERO;
        end else begin
            mode_r    <= mode_sel_s;
            pattern_r <= pattern_nxt_s;
            dir_r     <= dir_nxt_s;
            pwm_cnt_r <= pwm_cnt_r + PWM_WIDTH'(1);
            led_r     <= pattern_r & {LED_WIDTH{pwm_on_s}};
        end
    end

    assign led = led_r;

endmodule
